barrel_shift_pipe: RTL and testbench

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/barrel_shift_pipe_pkg.sv | 12 +
 rtl/barrel_shift_pipe_shifter8.sv | 18 +
 rtl/barrel_shift_pipe.sv | 91 +++++++++
 tb/tb_barrel_shift_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pipe_pkg.sv
// Shared shifter types and widths used by the pipelined barrel shifter and its shift core.
package barrel_shift_pipe_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
  } shift_req_t;

endpackage

// File: rtl/barrel_shift_pipe_shifter8.sv
// barrel_shifter8: purely combinational zero-filling logical right shift, one mux rank per shamt bit.
// Latency 0; no state, no backpressure.
module barrel_shifter8
  import barrel_shift_pipe_pkg::*;
(
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] ctrl,
  output logic [DATA_W-1:0]  out
);

  logic [DATA_W-1:0] rank1;
  logic [DATA_W-1:0] rank2;

  assign rank1 = ctrl[0] ? {1'b0, in[DATA_W-1:1]}       : in;
  assign rank2 = ctrl[1] ? {2'b00, rank1[DATA_W-1:2]}   : rank1;
  assign out   = ctrl[2] ? {4'h0, rank2[DATA_W-1:4]}    : rank2;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Two-stage valid/ready logical-right barrel shifter: result appears the edge after the one following acceptance.
// Backpressure: stage 2 holds while out_ready=0; in_ready drops only when both stages are full and stalled.
module barrel_shift_pipe
  import barrel_shift_pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SHAMT_W-1:0]     in_shamt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr
);

  logic                   s1_v_q, s1_v_d;
  shift_req_t             s1_req_q, s1_req_d;
  logic                   s2_v_q, s2_v_d;
  logic [DATA_W-1:0]      s2_data_q, s2_data_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic              accept;
  logic              adv1;
  logic [DATA_W-1:0] shifted;

  barrel_shifter8 u_shift (
    .in   (s1_req_q.data),
    .ctrl (s1_req_q.shamt),
    .out  (shifted)
  );

  assign adv1     = s1_v_q && (!s2_v_q || out_ready);
  assign in_ready = !s1_v_q || !s2_v_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_req_d  = s1_req_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    stall_d   = stall_q;

    if (accept) begin
      s1_v_d         = 1'b1;
      s1_req_d.data  = in_data;
      s1_req_d.shamt = in_shamt;
    end else if (adv1) begin
      s1_v_d = 1'b0;
    end

    // A retiring stage 2 is refilled in the same edge when stage 1 advances.
    if (adv1) begin
      s2_v_d    = 1'b1;
      s2_data_d = shifted;
    end else if (s2_v_q && out_ready) begin
      s2_v_d = 1'b0;
    end

    if (stall_clr) begin
      stall_d = '0;
    end else if (s2_v_q && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_req_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      stall_q   <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_req_q  <= s1_req_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboarded bench for barrel_shift_pipe with a 2-bit stall counter so saturation is reachable.
module tb_barrel_shift_pipe;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [2:0]   in_shamt;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [W-1:0] stall_cnt;
  logic         stall_clr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  barrel_shift_pipe #(.STALL_CNT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall-hold stability.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_data", {24'b0, out_data}, {24'b0, prev_data});
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_data  = out_data;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %0h, expected no output", out_data);
      end else begin
        chk("out_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [7:0] e);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
      end
      step();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    in_valid = 1'b0;
    in_data  = 8'hA5;
    in_shamt = 3'd6;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk("drain_queue", exp_q.size(), 32'd0);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    step();
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [7:0] e;
  } vec_t;

  vec_t vecs[4] = '{
    '{8'h5A, 3'd6, 8'h01},
    '{8'h01, 3'd0, 8'h01},
    '{8'h6D, 3'd2, 8'h1B},
    '{8'h01, 3'd1, 8'h00}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_shamt  = 3'd0;
    out_ready = 1'b0;
    stall_clr = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'h00);
    chk("rst_stall_cnt", {30'b0, stall_cnt}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();

    // Single request: latency and zero stall count.
    out_ready = 1'b1;
    send(8'hB5, 3'd3, 8'h16);
    @(negedge clk);
    chk("lat_not_yet", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_stall_cnt", {30'b0, stall_cnt}, 32'd0);
    step();

    // Back-to-back: results on consecutive cycles.
    send(8'hB5, 3'd0, 8'hB5);
    send(8'hFF, 3'd7, 8'h01);
    send(8'h80, 3'd4, 8'h08);
    @(negedge clk);
    chk("b2b_valid_2", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    chk("b2b_valid_3", {31'b0, out_valid}, 32'd1);
    step();
    foreach (vecs[i]) send(vecs[i].d, vecs[i].s, vecs[i].e);
    drain();

    // Two requests then 3 stalled edges with both stages full.
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    out_ready = 1'b0;
    send(8'h3C, 3'd2, 8'h0F);
    send(8'hA5, 3'd1, 8'h52);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      chk("full_out_data", {24'b0, out_data}, 32'h0F);
      step();
    end
    @(negedge clk);
    chk("stall_cnt_3", {30'b0, stall_cnt}, 32'd3);
    out_ready = 1'b1;
    drain();

    // Saturation after 5 stalled edges, then clear wins over a concurrent stall.
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    out_ready = 1'b0;
    send(8'hF0, 3'd5, 8'h07);
    step();
    repeat (5) step();
    @(negedge clk);
    chk("stall_sat", {30'b0, stall_cnt}, 32'd3);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    @(negedge clk);
    chk("stall_clr_prio", {30'b0, stall_cnt}, 32'd0);
    out_ready = 1'b1;
    drain();

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    send(8'h7E, 3'd1, 8'h3F);
    send(8'h81, 3'd7, 8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_data", {24'b0, out_data}, 32'h00);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_stall_cnt", {30'b0, stall_cnt}, 32'd0);
    step();
    out_ready = 1'b1;
    send(8'hC3, 3'd4, 8'h0C);
    drain();
    repeat (5) @(negedge clk);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
